// File: rtl/ps2_keymap_decoder.sv
// rtl/ps2_keymap_decoder.sv - PS/2 Set-2 scan-code decoder to per-key make/break pulses and held bitmap
module ps2_keymap_decoder #(
    parameter int                    NUM_KEYS        = 8,
    parameter logic [8*NUM_KEYS-1:0] KEY_CODES       = {8'h4D, 8'h76, 8'h29, 8'h5A,
                                                        8'h74, 8'h6B, 8'h72, 8'h75},
    parameter logic [NUM_KEYS-1:0]   KEY_EXT         = 8'b0000_1111,
    parameter bit                    SUPPRESS_REPEAT = 1'b1,
    parameter int                    TIMEOUT_CYCLES  = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                data_ready,
    input  logic [7:0]          data_in,
    output logic [NUM_KEYS-1:0] make_pulse,
    output logic [NUM_KEYS-1:0] break_pulse,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                any_make,
    output logic                proto_err
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_skip;
    logic                w_ext;
    logic [NUM_KEYS-1:0] w_sel;
    logic [NUM_KEYS-1:0] w_make;

    // One-hot select of the lowest table entry matching the byte and prefix kind
    always_comb begin
        w_ext = (r_state == EXT) || (r_state == EXT_BRK);
        w_sel = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_CODES[8*i +: 8] == data_in && KEY_EXT[i] == w_ext) begin
                w_sel    = '0;
                w_sel[i] = 1'b1;
            end
        end
        w_make = SUPPRESS_REPEAT ? (w_sel & ~key_held) : w_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_skip      <= '0;
            make_pulse  <= '0;
            break_pulse <= '0;
            key_held    <= '0;
            any_make    <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            make_pulse  <= '0;
            break_pulse <= '0;
            any_make    <= 1'b0;
            proto_err   <= 1'b0;
            if (data_ready) begin
                r_cnt <= '0;
                case (r_state)
                    IDLE: begin
                        if (data_in == 8'hE0) begin
                            r_state <= EXT;
                        end else if (data_in == 8'hF0) begin
                            r_state <= BRK;
                        end else if (data_in == 8'hE1) begin
                            r_state <= SKIP;
                            r_skip  <= 3'd7;
                        end else if (data_in == 8'hAA) begin
                            key_held <= '0;
                        end else if (data_in == 8'h00 || data_in == 8'hFF) begin
                            key_held  <= '0;
                            proto_err <= 1'b1;
                        end else begin
                            key_held   <= key_held | w_sel;
                            make_pulse <= w_make;
                            any_make   <= |w_make;
                        end
                    end
                    EXT: begin
                        if (data_in == 8'hF0) begin
                            r_state <= EXT_BRK;
                        end else if (data_in != 8'hE0) begin
                            key_held   <= key_held | w_sel;
                            make_pulse <= w_make;
                            any_make   <= |w_make;
                            r_state    <= IDLE;
                        end
                    end
                    BRK, EXT_BRK: begin
                        if (data_in == 8'hF0 || data_in == 8'hE0) begin
                            proto_err <= 1'b1;
                        end else begin
                            break_pulse <= w_sel;
                            key_held    <= key_held & ~w_sel;
                        end
                        r_state <= IDLE;
                    end
                    SKIP: begin
                        if (r_skip <= 3'd1) begin
                            r_skip  <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_skip <= r_skip - 3'd1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_state != IDLE && TIMEOUT_CYCLES != 0) begin
                // Stalled prefix: abandon it but keep the held bitmap
                if (r_cnt == LAST) begin
                    proto_err <= 1'b1;
                    r_state   <= IDLE;
                    r_cnt     <= '0;
                    r_skip    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// tb/tb_ps2_keymap_decoder.sv - directed table-driven bench for ps2_keymap_decoder
module tb_ps2_keymap_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_ready = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] make_a, brk_a, held_a, make_b, brk_b, held_b;
    logic       any_a, err_a, any_b, err_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ps2_keymap_decoder #(.TIMEOUT_CYCLES(16), .SUPPRESS_REPEAT(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_ready(data_ready), .data_in(data_in),
        .make_pulse(make_a), .break_pulse(brk_a), .key_held(held_a),
        .any_make(any_a), .proto_err(err_a)
    );

    ps2_keymap_decoder #(.TIMEOUT_CYCLES(16), .SUPPRESS_REPEAT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_ready(data_ready), .data_in(data_in),
        .make_pulse(make_b), .break_pulse(brk_b), .key_held(held_b),
        .any_make(any_b), .proto_err(err_b)
    );

    typedef struct {
        logic [7:0] b;
        logic [7:0] make;
        logic [7:0] brk;
        logic [7:0] held;
        logic       err;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One byte strobe; returns at the following negedge with its results visible
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        data_ready = 1'b1;
        data_in    = b;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    task automatic chk_a(input string name, input logic [7:0] m, input logic [7:0] br,
                         input logic [7:0] h, input logic e);
        chk({name, " make"}, make_a, m);
        chk({name, " brk"},  brk_a,  br);
        chk({name, " held"}, held_a, h);
        chk({name, " any"},  any_a,  |m);
        chk({name, " err"},  err_a,  e);
    endtask

    initial begin
        int seen_at;

        vq.push_back('{8'hE0, 8'h00, 8'h00, 8'h00, 1'b0});
        vq.push_back('{8'h75, 8'h01, 8'h00, 8'h01, 1'b0});
        vq.push_back('{8'hE0, 8'h00, 8'h00, 8'h01, 1'b0});
        vq.push_back('{8'hF0, 8'h00, 8'h00, 8'h01, 1'b0});
        vq.push_back('{8'h75, 8'h00, 8'h01, 8'h00, 1'b0});
        vq.push_back('{8'h75, 8'h00, 8'h00, 8'h00, 1'b0});
        vq.push_back('{8'hE0, 8'h00, 8'h00, 8'h00, 1'b0});
        vq.push_back('{8'h5A, 8'h00, 8'h00, 8'h00, 1'b0});
        vq.push_back('{8'hE0, 8'h00, 8'h00, 8'h00, 1'b0});
        vq.push_back('{8'h72, 8'h02, 8'h00, 8'h02, 1'b0});
        vq.push_back('{8'hE0, 8'h00, 8'h00, 8'h02, 1'b0});
        vq.push_back('{8'hF0, 8'h00, 8'h00, 8'h02, 1'b0});
        vq.push_back('{8'h72, 8'h00, 8'h02, 8'h00, 1'b0});
        vq.push_back('{8'hF0, 8'h00, 8'h00, 8'h00, 1'b0});
        vq.push_back('{8'hF0, 8'h00, 8'h00, 8'h00, 1'b1});
        vq.push_back('{8'h29, 8'h20, 8'h00, 8'h20, 1'b0});
        vq.push_back('{8'hF0, 8'h00, 8'h00, 8'h20, 1'b0});
        vq.push_back('{8'h29, 8'h00, 8'h20, 8'h00, 1'b0});
        vq.push_back('{8'hE0, 8'h00, 8'h00, 8'h00, 1'b0});
        vq.push_back('{8'hE0, 8'h00, 8'h00, 8'h00, 1'b0});
        vq.push_back('{8'h75, 8'h01, 8'h00, 8'h01, 1'b0});
        vq.push_back('{8'hE0, 8'h00, 8'h00, 8'h01, 1'b0});
        vq.push_back('{8'h6B, 8'h04, 8'h00, 8'h05, 1'b0});
        vq.push_back('{8'hF0, 8'h00, 8'h00, 8'h05, 1'b0});
        vq.push_back('{8'h76, 8'h00, 8'h40, 8'h05, 1'b0});
        vq.push_back('{8'h00, 8'h00, 8'h00, 8'h00, 1'b1});

        repeat (3) @(negedge clk);
        chk_a("reset", 8'h00, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            send(vq[i].b);
            chk_a($sformatf("vec%0d", i), vq[i].make, vq[i].brk, vq[i].held, vq[i].err);
        end

        // Typematic repeats: suppressed on A, pulsed every time on B
        for (int i = 0; i < 3; i++) begin
            send(8'h5A);
            chk($sformatf("rep%0d make_a", i), make_a, (i == 0) ? 8'h10 : 8'h00);
            chk($sformatf("rep%0d make_b", i), make_b, 8'h10);
            chk($sformatf("rep%0d any_b", i),  any_b,  1'b1);
            chk($sformatf("rep%0d held_a", i), held_a, 8'h10);
        end
        send(8'hF0);
        send(8'h5A);
        chk("rep rel brk_b", brk_b, 8'h10);
        chk("rep rel held_b", held_b, 8'h00);

        // Pause sequence is swallowed whole
        begin
            logic [7:0] pause [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
            for (int i = 0; i < 8; i++) begin
                send(pause[i]);
                chk_a($sformatf("pause%0d", i), 8'h00, 8'h00, 8'h00, 1'b0);
            end
        end
        send(8'h29);
        chk_a("after pause", 8'h20, 8'h00, 8'h20, 1'b0);
        send(8'hF0);
        send(8'h29);

        // Prefix timeout after 16 idle cycles
        send(8'hE0);
        seen_at = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (err_a === 1'b1) begin
                seen_at = i;
                break;
            end
        end
        chk("timeout cycle", seen_at, 16);
        send(8'h74);
        chk_a("post timeout 74", 8'h00, 8'h00, 8'h00, 1'b0);

        // BAT ok clears holds without break pulses
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'h6B);
        chk("hold two", held_a, 8'h05);
        send(8'hAA);
        chk_a("bat", 8'h00, 8'h00, 8'h00, 1'b0);

        // Asynchronous reset mid-prefix
        send(8'hE0); send(8'h75);
        send(8'hE0);
        #2 rst_n = 1'b0;
        #1;
        chk_a("async reset", 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h75);
        chk_a("prefix dropped", 8'h00, 8'h00, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_keymap_decoder.md
Name: ps2_keymap_decoder

Overview:
Parametrised PS/2 Set-2 scan-code decoder. It sits between the PS/2 byte receiver and game control logic. It maps a configurable table of NUM_KEYS keys, each either plain or E0-extended, to per-key outputs:
- one-cycle make pulses
- one-cycle break pulses
- a level "held" bitmap

Also provided: typematic-repeat suppression, prefix timeout, Pause (E1) sequence skipping, and protocol-error/keyboard-reset handling.

Parameters:
NUM_KEYS, 8, number of table entries (1..32)
KEY_CODES, {8'h4D,8'h76,8'h29,8'h5A,8'h74,8'h6B,8'h72,8'h75}, 8*NUM_KEYS packed final-byte codes; entry i = bits [8i+7:8i] (0 up, 1 down, 2 left, 3 right, 4 enter, 5 space, 6 esc, 7 P)
KEY_EXT, 8'b0000_1111, bit i = 1: entry i requires E0 prefix
SUPPRESS_REPEAT, 1, 1: no make pulse while key already held
TIMEOUT_CYCLES, 50000, max clocks between prefix and final byte; 0 disables timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data_ready  in  1  one-cycle strobe, data_in valid
data_in  in  8  received byte
make_pulse  out  NUM_KEYS  one-cycle pulse per key press
break_pulse  out  NUM_KEYS  one-cycle pulse per key release
key_held  out  NUM_KEYS  level, key currently down
any_make  out  1  OR of make_pulse, same cycle
proto_err  out  1  one-cycle pulse on sequence error/timeout/overrun

Behaviour:
- Reset (async assert, sync deassert use):
  - all outputs 0
  - state IDLE
  - timeout counter 0
  - skip counter 0
- All outputs are registered. Pulses appear on the clock edge after the data_ready cycle (latency 1) and last exactly one cycle. Outputs are cleared by default every cycle.
- States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP.
- IDLE:
  - E0 -> EXT
  - F0 -> BRK
  - E1 -> SKIP with skip count 7
  - AA (BAT ok) -> key_held cleared, stay IDLE
  - 00 or FF (overrun) -> key_held cleared, proto_err, stay IDLE
  - any other byte is a plain make final byte
- EXT:
  - F0 -> EXT_BRK
  - E0 -> stay EXT
  - other -> extended make final byte, -> IDLE
- BRK:
  - F0 or E0 -> proto_err, -> IDLE
  - other -> plain break final byte, -> IDLE
- EXT_BRK:
  - F0 or E0 -> proto_err, -> IDLE
  - other -> extended break final byte, -> IDLE
- SKIP: each data_ready decrements the skip count. Leave to IDLE after the 7th byte. No outputs are produced.
- Lookup on a final byte: entry i matches if KEY_CODES[i] == data_in and KEY_EXT[i] equals the extended flag. Lowest matching index wins. No match: no pulse, state still returns to IDLE.
- Make on matched i:
  - key_held[i] <= 1
  - make_pulse[i] <= 1, unless SUPPRESS_REPEAT and key_held[i] was already 1
- Break on matched i:
  - break_pulse[i] <= 1 and key_held[i] <= 0, even if not held (release after reset must be visible)
- Timeout: the counter clears on every data_ready and increments each cycle in EXT, BRK, EXT_BRK or SKIP. If it reaches TIMEOUT_CYCLES-1 with no data_ready:
  - proto_err pulse
  - state -> IDLE
  - counter cleared
  - key_held unchanged
  - data_ready in the same cycle takes priority over timeout
- Held keys are independent. Simultaneous holds of any subset are legal.
- Reset mid-sequence: the partial prefix is discarded and key_held is cleared.
- The block never back-pressures; data_ready in consecutive cycles is processed at full rate.

Test Plan:
- Bytes E0 75 -> make_pulse=8'h01 for one cycle, 1 clk after the 75 strobe; key_held=8'h01; any_make=1. Then E0 F0 75 -> break_pulse=8'h01, key_held=8'h00.
- Byte 5A three times (typematic), SUPPRESS_REPEAT=1 -> one make_pulse[4] only; key_held[4]=1 throughout. Repeat with SUPPRESS_REPEAT=0 -> three pulses.
- Plain 75 (no E0) -> no pulse (KEY_EXT[0]=1). E0 5A -> no pulse (KEY_EXT[4]=0). State back to IDLE in both cases; a following E0 72 -> make_pulse=8'h02.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 29 -> no pulses during the sequence; make_pulse=8'h20 after 29.
- E0 then no byte for TIMEOUT_CYCLES (TIMEOUT_CYCLES=16 in bench) -> proto_err pulse; a next byte 74 is treated as plain (no pulse). F0 F0 -> proto_err.
- Hold up and left (E0 75, E0 6B) -> key_held=8'h05. Byte AA -> key_held=8'h00, no break pulses. Then assert rst_n=0 mid E0 -> all outputs 0 asynchronously.
